branch_recovery_ctrl: RTL and testbench

// - Sequences branch resolution in EX. Consumes the new-PC select and the predicted-PC compare from the PC evaluation stage.
// - On a misprediction it drives a one-cycle front-end redirect and a multi-cycle pipeline flush.
// - Sends one predictor-update transaction per resolved branch over a valid/ready handshake.
// - Stalls EX when a new update cannot be buffered.
// - Sits between the EX-stage PC evaluation logic, the IF PC mux, and the branch predictor/BTB.

---
 rtl/branch_recovery_ctrl_if.sv | 27 ++
 rtl/branch_recovery_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_recovery_ctrl_if.sv
// Predictor-update channel: one resolved branch per valid/ready transfer
// from the branch recovery controller to the branch predictor/BTB.
interface branch_recovery_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             Upd_Valid;
  logic [WIDTH-1:0] Upd_PC;
  logic [WIDTH-1:0] Upd_Target;
  logic             Upd_Taken;
  logic             Upd_Ready;

  modport master (
    output Upd_Valid,
    output Upd_PC,
    output Upd_Target,
    output Upd_Taken,
    input  Upd_Ready
  );

  modport slave (
    input  Upd_Valid,
    input  Upd_PC,
    input  Upd_Target,
    input  Upd_Taken,
    output Upd_Ready
  );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// EX-stage branch resolution: redirects IF and flushes IF/ID + ID/EX on a
// misprediction, and posts one predictor update per consumed branch.
module branch_recovery_ctrl #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_Br_Valid,
  input  logic                   i_Br_Taken,
  input  logic                   i_Pred_Taken,
  input  logic                   i_PPC_Eq,
  input  logic [WIDTH-1:0]       i_New_PC,
  input  logic [WIDTH-1:0]       i_Br_PC,
  output logic                   o_Redirect,
  output logic [WIDTH-1:0]       o_Redirect_PC,
  output logic                   o_Flush,
  output logic                   o_Stall,
  output logic [CNT_W-1:0]       o_Mispred_Cnt,
  branch_recovery_ctrl_if.master upd
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             upd_valid_q, upd_valid_d;
  logic [WIDTH-1:0] upd_pc_q, upd_pc_d;
  logic [WIDTH-1:0] upd_target_q, upd_target_d;
  logic             upd_taken_q, upd_taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall;
  logic consume;
  logic mispred;

  // Branches arriving in FLUSH are wrong-path: never consumed or stalled.
  always_comb begin
    stall   = i_Br_Valid & (state_q == IDLE) & upd_valid_q & ~upd.Upd_Ready;
    consume = i_Br_Valid & (state_q == IDLE) & ~stall;
    mispred = consume & ((i_Br_Taken != i_Pred_Taken) | (i_Br_Taken & ~i_PPC_Eq));
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_d    = mispred;
    redirect_pc_d = redirect_pc_q;
    upd_valid_d   = upd_valid_q;
    upd_pc_d      = upd_pc_q;
    upd_target_d  = upd_target_q;
    upd_taken_d   = upd_taken_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (mispred) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mispred) begin
      redirect_pc_d = i_New_PC;
    end

    // A load in the same cycle as an accept overrides the drain.
    if (upd_valid_q & upd.Upd_Ready) begin
      upd_valid_d = 1'b0;
    end
    if (consume) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = i_Br_PC;
      upd_target_d = i_New_PC;
      upd_taken_d  = i_Br_Taken;
    end

    if (mispred && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      flush_cnt_q   <= 4'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
      upd_taken_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_target_q  <= upd_target_d;
      upd_taken_q   <= upd_taken_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_Redirect     = redirect_q;
  assign o_Redirect_PC  = redirect_pc_q;
  assign o_Flush        = (state_q == FLUSH);
  assign o_Stall        = stall;
  assign o_Mispred_Cnt  = cnt_q;
  assign upd.Upd_Valid  = upd_valid_q;
  assign upd.Upd_PC     = upd_pc_q;
  assign upd.Upd_Target = upd_target_q;
  assign upd.Upd_Taken  = upd_taken_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed + randomized bench for branch_recovery_ctrl, checked each cycle
// against a queue-based behavioural model of redirect/flush/update/count.
module tb_branch_recovery_ctrl;

  localparam int WIDTH        = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_valid, br_taken, pred_taken, ppc_eq;
  logic [WIDTH-1:0] new_pc, br_pc;
  logic             redirect, flush, stall;
  logic [WIDTH-1:0] redirect_pc;
  logic [CNT_W-1:0] mispred_cnt;

  branch_recovery_ctrl_if #(.WIDTH(WIDTH)) upd_bus ();

  branch_recovery_ctrl #(
    .WIDTH(WIDTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_Br_Valid   (br_valid),
    .i_Br_Taken   (br_taken),
    .i_Pred_Taken (pred_taken),
    .i_PPC_Eq     (ppc_eq),
    .i_New_PC     (new_pc),
    .i_Br_PC      (br_pc),
    .o_Redirect   (redirect),
    .o_Redirect_PC(redirect_pc),
    .o_Flush      (flush),
    .o_Stall      (stall),
    .o_Mispred_Cnt(mispred_cnt),
    .upd          (upd_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: flush countdown in cycles, pending update as a queue.
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] tgt;
    logic             tk;
  } upd_t;

  upd_t             m_q[$];
  int               m_flush_left;
  int               m_cnt;
  bit               m_redirect;
  logic [WIDTH-1:0] m_rpc;

  task automatic model_reset();
    m_q.delete();
    m_flush_left = 0;
    m_cnt        = 0;
    m_redirect   = 0;
    m_rpc        = '0;
  endtask

  function automatic bit exp_stall();
    return br_valid && (m_flush_left == 0) && (m_q.size() > 0) && !upd_bus.Upd_Ready;
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, ".redirect"},    64'(redirect),    64'(m_redirect));
    chk({ph, ".redirect_pc"}, 64'(redirect_pc), 64'(m_rpc));
    chk({ph, ".flush"},       64'(flush),       64'(m_flush_left > 0));
    chk({ph, ".stall"},       64'(stall),       64'(exp_stall()));
    chk({ph, ".upd_valid"},   64'(upd_bus.Upd_Valid), 64'(m_q.size() > 0));
    chk({ph, ".cnt"},         64'(mispred_cnt), 64'(m_cnt));
    if (m_q.size() > 0) begin
      chk({ph, ".upd_pc"},     64'(upd_bus.Upd_PC),     64'(m_q[0].pc));
      chk({ph, ".upd_target"}, 64'(upd_bus.Upd_Target), 64'(m_q[0].tgt));
      chk({ph, ".upd_taken"},  64'(upd_bus.Upd_Taken),  64'(m_q[0].tk));
    end
  endtask

  task automatic model_step(input string ph);
    bit   st, cons, mis;
    upd_t e;
    st   = exp_stall();
    cons = br_valid && (m_flush_left == 0) && !st;
    mis  = cons && ((br_taken != pred_taken) || (br_taken && !ppc_eq));
    if ((m_q.size() > 0) && upd_bus.Upd_Ready) void'(m_q.pop_front());
    if (cons) begin
      e.pc  = br_pc;
      e.tgt = new_pc;
      e.tk  = br_taken;
      m_q.push_back(e);
      $display("[%0t] %s: branch pc=0x%0h target=0x%0h taken=%0d mispred=%0d",
               $time, ph, br_pc, new_pc, br_taken, mis);
    end
    if (m_flush_left > 0) m_flush_left--;
    if (mis) begin
      m_flush_left = FLUSH_CYCLES;
      m_rpc        = new_pc;
      m_cnt        = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
    m_redirect = mis;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic bv, input logic tk, input logic pd, input logic eq,
                       input logic [WIDTH-1:0] npc, input logic [WIDTH-1:0] bpc,
                       input logic rdy, input string ph);
    br_valid          = bv;
    br_taken          = tk;
    pred_taken        = pd;
    ppc_eq            = eq;
    new_pc            = npc;
    br_pc             = bpc;
    upd_bus.Upd_Ready = rdy;
    #1;
    check_outputs(ph);
    model_step(ph);
    @(negedge clk);
  endtask

  task automatic idle(input string ph);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, ph);
  endtask

  initial begin
    rst_n             = 1'b0;
    br_valid          = 1'b0;
    br_taken          = 1'b0;
    pred_taken        = 1'b0;
    ppc_eq            = 1'b0;
    new_pc            = '0;
    br_pc             = '0;
    upd_bus.Upd_Ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // T1: correctly predicted taken branch
    drive(1, 1, 1, 1, 32'h100, 32'h40, 1, "t1");
    chk("t1_upd_valid",  64'(upd_bus.Upd_Valid),  64'd1);
    chk("t1_upd_target", 64'(upd_bus.Upd_Target), 64'h100);
    chk("t1_no_redirect", 64'(redirect), 64'd0);
    idle("t1_idle");

    // T2: direction mispredict
    drive(1, 1, 0, 1, 32'h2000, 32'h80, 1, "t2");
    chk("t2_redirect",    64'(redirect),    64'd1);
    chk("t2_redirect_pc", 64'(redirect_pc), 64'h2000);
    chk("t2_cnt",         64'(mispred_cnt), 64'd1);
    idle("t2_f1");
    chk("t2_redirect_once", 64'(redirect), 64'd0);
    chk("t2_flush_2nd",     64'(flush),    64'd1);
    idle("t2_f2");
    chk("t2_flush_end",     64'(flush),    64'd0);

    // T3: target mispredict with wrong-path branches during the flush
    drive(1, 1, 1, 0, 32'h3000, 32'hC0, 1, "t3");
    drive(1, 0, 1, 1, 32'h3100, 32'hC4, 1, "t3_wp1");
    drive(1, 1, 0, 0, 32'h3200, 32'hC8, 1, "t3_wp2");
    chk("t3_cnt", 64'(mispred_cnt), 64'd2);
    chk("t3_no_wp_update", 64'(upd_bus.Upd_Valid), 64'd0);
    idle("t3_idle");

    // T4: backpressure stalls the next branch, then accept-and-load
    drive(1, 1, 1, 1, 32'h4000, 32'h100, 0, "t4_load");
    drive(1, 0, 0, 1, 32'h5000, 32'h104, 0, "t4_stall1");
    drive(1, 0, 0, 1, 32'h5000, 32'h104, 0, "t4_stall2");
    chk("t4_held_pc", 64'(upd_bus.Upd_PC), 64'h100);
    drive(1, 0, 0, 1, 32'h5000, 32'h104, 1, "t4_accept");
    chk("t4_valid_kept", 64'(upd_bus.Upd_Valid), 64'd1);
    chk("t4_new_pc",     64'(upd_bus.Upd_PC),    64'h104);
    idle("t4_idle");

    // T6: asynchronous reset in the middle of a flush
    drive(1, 0, 1, 1, 32'h6000, 32'h180, 1, "t6");
    chk("t6_pre_flush", 64'(flush), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flush",     64'(flush),             64'd0);
    chk("t6_rst_redirect",  64'(redirect),          64'd0);
    chk("t6_rst_upd_valid", 64'(upd_bus.Upd_Valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 1, 32'h6100, 32'h200, 1, "t6_post");
    chk("t6_post_valid",  64'(upd_bus.Upd_Valid),  64'd1);
    chk("t6_post_target", 64'(upd_bus.Upd_Target), 64'h6100);

    // T5: counter saturation
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, 1, 32'h7000 + 32'(i * 4), 32'h300 + 32'(i * 4), 1, "t5");
      idle("t5_f1");
      idle("t5_f2");
    end
    chk("t5_saturated", 64'(mispred_cnt), 64'(CNT_MAX));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic bv, tk, pd, eq, rdy;
      bv  = ($urandom_range(0, 9) < 6);
      tk  = 1'($urandom);
      pd  = ($urandom_range(0, 9) < 8) ? tk : ~tk;
      eq  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 6);
      drive(bv, tk, pd, eq, $urandom, $urandom, rdy, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
